// File: rtl/bram0_loader_pkg.sv
// loader_pkg: shared state encoding, row geometry and count clamp for the BRAM0 loader
package loader_pkg;
    localparam int CNT_BIT       = 31;
    localparam int BYTES_PER_ROW = 4;
    localparam int MEM_SIZE      = 256;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    function automatic logic [CNT_BIT-1:0] clamp_count(input logic [CNT_BIT-1:0] c, input logic [CNT_BIT-1:0] limit);
        return (c > limit) ? limit : c;
    endfunction
endpackage

// File: rtl/bram0_loader_if.sv
// bram0_loader_if: byte stream handshake plus BRAM0 write port of the loader
interface bram0_loader_if #(
    parameter int DWIDTH        = 32,
    parameter int AWIDTH        = 8,
    parameter int IN_DATA_WIDTH = 8
);
    logic                     s_valid_i;
    logic [IN_DATA_WIDTH-1:0] s_data_i;
    logic                     s_ready_o;
    logic [AWIDTH-1:0]        addr_b0_o;
    logic                     ce_b0_o;
    logic                     we_b0_o;
    logic [DWIDTH-1:0]        d_b0_o;

    modport master (
        input  s_valid_i, s_data_i,
        output s_ready_o, addr_b0_o, ce_b0_o, we_b0_o, d_b0_o
    );

    modport slave (
        output s_valid_i, s_data_i,
        input  s_ready_o, addr_b0_o, ce_b0_o, we_b0_o, d_b0_o
    );
endinterface

// File: rtl/bram0_loader_packer.sv
// byte_packer: inserts bytes little-endian into a row and flags the push that completes it
module byte_packer
    import loader_pkg::*;
#(
    parameter int W     = 8,
    parameter int LANES = BYTES_PER_ROW
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [W-1:0]     data_i,
    output logic [W*LANES-1:0] row_o,
    output logic             row_valid_o
);
    localparam int LW = $clog2(LANES);

    logic [LW-1:0]      lane_q, lane_d;
    logic [W*LANES-1:0] row_q, row_d;

    assign row_valid_o = push_i && lane_q == LW'(LANES - 1);

    // row as it looks with the incoming byte dropped into its lane, so the completing push sees the full row
    always_comb begin
        row_o = row_q;
        row_o[W*lane_q +: W] = data_i;
        row_d = push_i ? row_o : row_q;
        lane_d = clear_i ? '0 : push_i ? lane_q + LW'(1) : lane_q;
    end

    // lane pointer and partial row storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_q <= '0;
            row_q  <= '0;
        end else begin
            lane_q <= lane_d;
            row_q  <= row_d;
        end
    end
endmodule

// File: rtl/bram0_loader.sv
// bram0_loader: packs a byte stream into rows, writes them to BRAM0 and starts the accessor stage
module bram0_loader
    import loader_pkg::*;
#(
    parameter int CNT_BIT       = 31,
    parameter int DWIDTH        = 32,
    parameter int AWIDTH        = 8,
    parameter int MEM_SIZE      = 256,
    parameter int IN_DATA_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start_load_i,
    input  logic [CNT_BIT-1:0] load_count_i,
    bram0_loader_if.master     bus,
    output logic               idle_o,
    output logic               run_o,
    output logic               done_o,
    output logic               start_run_o,
    output logic [CNT_BIT-1:0] run_count_o
);
    state_t             state_q, state_d;
    logic [CNT_BIT-1:0] cnt_q, cnt_d;
    logic [CNT_BIT-1:0] row_q, row_d;
    logic [CNT_BIT-1:0] run_count_q, run_count_d;
    logic [AWIDTH-1:0]  addr_q, addr_d;
    logic [DWIDTH-1:0]  data_q, data_d;
    logic               ce_q, ce_d;
    logic               take_start, ready, push, last_row_done, row_valid;
    logic [DWIDTH-1:0]  row;

    assign take_start    = state_q == S_IDLE && start_load_i;
    assign ready         = state_q == S_RUN && row_q < cnt_q;
    assign push          = bus.s_valid_i && ready;
    assign last_row_done = state_q == S_RUN && row_q == cnt_q;

    byte_packer #(.W(IN_DATA_WIDTH), .LANES(BYTES_PER_ROW)) u_packer (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear_i     (take_start),
        .push_i      (push),
        .data_i      (bus.s_data_i),
        .row_o       (row),
        .row_valid_o (row_valid)
    );

    // next state, row bookkeeping and BRAM0 port values; RUN ends the cycle after the last row write
    always_comb begin
        state_d     = state_q == S_IDLE ? (start_load_i ? S_RUN : S_IDLE)
                    : state_q == S_RUN  ? (last_row_done ? S_DONE : S_RUN) : S_IDLE;
        cnt_d       = take_start ? clamp_count(load_count_i, CNT_BIT'(MEM_SIZE)) : cnt_q;
        row_d       = take_start ? '0 : row_valid ? row_q + CNT_BIT'(1) : row_q;
        run_count_d = last_row_done ? cnt_q : run_count_q;
        ce_d        = row_valid;
        addr_d      = row_valid ? row_q[AWIDTH-1:0] : addr_q;
        data_d      = row_valid ? row : data_q;
    end

    // state, counters and registered BRAM0 port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            row_q       <= '0;
            run_count_q <= '0;
            ce_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            run_count_q <= run_count_d;
            ce_q        <= ce_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    assign bus.s_ready_o = ready;
    assign bus.ce_b0_o   = ce_q;
    assign bus.we_b0_o   = ce_q;
    assign bus.addr_b0_o = addr_q;
    assign bus.d_b0_o    = data_q;
    assign idle_o        = state_q == S_IDLE;
    assign run_o         = state_q == S_RUN;
    assign done_o        = state_q == S_DONE;
    assign start_run_o   = state_q == S_DONE && run_count_q != '0;
    assign run_count_o   = run_count_q;
endmodule

// File: tb/tb_bram0_loader.sv
// tb_bram0_loader: random and directed loads checked every cycle against a byte-level reference model
module tb_bram0_loader;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_load_i = 1'b0;
    logic [30:0] load_count_i = '0;
    logic        idle_o, run_o, done_o, start_run_o;
    logic [30:0] run_count_o;

    bram0_loader_if bus();

    bram0_loader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_load_i (start_load_i),
        .load_count_i (load_count_i),
        .bus          (bus),
        .idle_o       (idle_o),
        .run_o        (run_o),
        .done_o       (done_o),
        .start_run_o  (start_run_o),
        .run_count_o  (run_count_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: phase 0 idle, 1 loading, 2 done; bytes counted individually
    int         m_phase = 0, m_cnt = 0, m_bytes = 0, m_run_count = 0, m_r = 0, last_acc = 0;
    logic       m_ce = 1'b0;
    logic [7:0] m_addr = '0;
    logic [31:0] m_d = '0;
    logic [7:0] m_buf[$];

    function automatic logic m_ready();
        return m_phase == 1 && m_bytes < 4 * m_cnt;
    endfunction

    // advance the model on each edge from the inputs the DUT sees
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = 0; m_cnt = 0; m_bytes = 0; m_run_count = 0;
            m_ce = 1'b0; m_addr = '0; m_d = '0;
            m_buf.delete();
        end else begin
            cyc++;
            m_ce = 1'b0;
            if (m_phase == 0) begin
                if (start_load_i) begin
                    m_phase = 1;
                    m_cnt = (load_count_i > 31'd256) ? 256 : int'(load_count_i);
                    m_bytes = 0;
                    m_buf.delete();
                end
            end else if (m_phase == 2) begin
                m_phase = 0;
            end else if (m_bytes == 4 * m_cnt) begin
                m_phase = 2;
                m_run_count = m_cnt;
            end else if (bus.s_valid_i) begin
                m_buf.push_back(bus.s_data_i);
                m_bytes++;
                if (m_bytes % 4 == 0) begin
                    m_r = m_bytes / 4 - 1;
                    m_ce = 1'b1;
                    m_addr = 8'(m_r);
                    m_d = {m_buf[4*m_r+3], m_buf[4*m_r+2], m_buf[4*m_r+1], m_buf[4*m_r]};
                    last_acc = cyc;
                end
            end
        end
    end

    logic [39:0] wlog[$];
    int          sr_n = 0, sr_cyc = 0;

    // compare every output against the model and log observed writes and start pulses
    always @(negedge clk) begin
        chk("idle_o", idle_o, m_phase == 0);
        chk("run_o", run_o, m_phase == 1);
        chk("done_o", done_o, m_phase == 2);
        chk("start_run_o", start_run_o, m_phase == 2 && m_cnt != 0);
        chk("run_count_o", run_count_o, 64'(m_run_count));
        chk("s_ready_o", bus.s_ready_o, m_ready());
        chk("ce_b0_o", bus.ce_b0_o, m_ce);
        chk("we_b0_o", bus.we_b0_o, m_ce);
        chk("addr_b0_o", bus.addr_b0_o, m_addr);
        chk("d_b0_o", bus.d_b0_o, m_d);
        if (bus.ce_b0_o) wlog.push_back({bus.addr_b0_o, bus.d_b0_o});
        if (start_run_o) begin
            sr_n++;
            sr_cyc = cyc;
        end
    end

    logic [7:0] tx[$];

    task automatic fill(input int n);
        tx.delete();
        for (int i = 0; i < n; i++) tx.push_back(8'($urandom));
    endtask

    task automatic start_load(input int c);
        start_load_i = 1'b1;
        load_count_i = 31'(c);
        @(posedge clk); #1;
        start_load_i = 1'b0;
    endtask

    // offer tx bytes in order; pct<0 toggles valid every other cycle
    task automatic stream(input int n, input int pct, input int max_cyc, output int got);
        int k = 0;
        got = 0;
        while (got < n && k < max_cyc) begin
            bus.s_valid_i = pct < 0 ? (k % 2 == 0) : (int'($urandom_range(99)) < pct);
            bus.s_data_i = tx[got];
            @(negedge clk);
            if (bus.s_valid_i && bus.s_ready_o) got++;
            @(posedge clk); #1;
            k++;
        end
        bus.s_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!idle_o && k < max_cyc);
        chk("reach_idle", idle_o, 1);
    endtask

    task automatic clear_logs();
        wlog.delete();
        sr_n = 0;
    endtask

    initial begin
        int got, t0, c, pct;
        bus.s_valid_i = 1'b0;
        bus.s_data_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_idle", idle_o, 1);
        chk("rst_run_count", run_count_o, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // count 2, bytes 01..08 at full rate
        clear_logs();
        tx.delete();
        for (int i = 1; i <= 8; i++) tx.push_back(8'(i));
        start_load(2);
        stream(8, 100, 50, got);
        wait_idle(10);
        chk("t1_bytes", got, 8);
        chk("t1_nwrites", wlog.size(), 2);
        chk("t1_w0", wlog[0], {8'h00, 32'h04030201});
        chk("t1_w1", wlog[1], {8'h01, 32'h08070605});
        chk("t1_start_runs", sr_n, 1);
        chk("t1_start_gap", sr_cyc - last_acc, 1);
        chk("t1_run_count", run_count_o, 2);

        // count 1 with valid toggling
        clear_logs();
        tx.delete();
        tx.push_back(8'hAA); tx.push_back(8'hBB); tx.push_back(8'hCC); tx.push_back(8'hDD);
        start_load(1);
        stream(4, -1, 50, got);
        wait_idle(10);
        chk("t2_nwrites", wlog.size(), 1);
        chk("t2_w0", wlog[0], {8'h00, 32'hDDCCBBAA});
        chk("t2_run_count", run_count_o, 1);

        // count 0
        clear_logs();
        start_load(0);
        t0 = cyc;
        chk("t3_run", run_o, 1);
        wait_idle(10);
        chk("t3_idle_edges", cyc - t0, 2);
        chk("t3_nwrites", wlog.size(), 0);
        chk("t3_start_runs", sr_n, 0);
        chk("t3_run_count", run_count_o, 0);

        // count 300 clamps to 256 rows
        clear_logs();
        fill(1030);
        start_load(300);
        stream(1030, 100, 1040, got);
        wait_idle(10);
        chk("t4_bytes", got, 1024);
        chk("t4_nwrites", wlog.size(), 256);
        chk("t4_first_addr", wlog[0][39:32], 8'd0);
        chk("t4_last_addr", wlog[255][39:32], 8'd255);
        chk("t4_w0_data", wlog[0][31:0], {tx[3], tx[2], tx[1], tx[0]});
        chk("t4_run_count", run_count_o, 256);
        chk("t4_start_runs", sr_n, 1);

        // reset after 6 bytes of a count-4 load, then reload
        clear_logs();
        fill(16);
        start_load(4);
        stream(6, 100, 50, got);
        reset_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_idle", idle_o, 1);
        chk("t5_rst_ce", bus.ce_b0_o, 0);
        chk("t5_rst_addr", bus.addr_b0_o, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_nwrites", wlog.size(), 1);
        clear_logs();
        fill(4);
        start_load(1);
        stream(4, 100, 50, got);
        wait_idle(10);
        chk("t5_reload_nwrites", wlog.size(), 1);
        chk("t5_reload_w0", wlog[0], {8'h00, tx[3], tx[2], tx[1], tx[0]});

        // start pulses during RUN and DONE are ignored
        clear_logs();
        fill(8);
        start_load(2);
        fork
            stream(8, 100, 50, got);
            begin
                @(posedge clk); #1;
                start_load_i = 1'b1; load_count_i = 31'd9;
                @(posedge clk); #1;
                start_load_i = 1'b0;
            end
        join
        start_load_i = 1'b1; load_count_i = 31'd9;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start_load_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_idle", idle_o, 1);
        chk("t6_start_runs", sr_n, 1);
        chk("t6_run_count", run_count_o, 2);
        chk("t6_nwrites", wlog.size(), 2);

        // randomized loads
        for (int it = 0; it < 15; it++) begin
            c = $urandom_range(6);
            pct = 30 + $urandom_range(70);
            clear_logs();
            fill(4 * c);
            start_load(c);
            stream(4 * c, pct, 300, got);
            wait_idle(10);
            chk("rnd_bytes", got, 4 * c);
            chk("rnd_nwrites", wlog.size(), c);
            chk("rnd_start_runs", sr_n, c != 0);
            repeat ($urandom_range(3)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
